// File: rtl/gonso_pkg.sv
// rtl/gonso_pkg.sv - register offsets, STATUS/CTRL bit positions and decode helpers for the color FIFO
package gonso_pkg;

  localparam logic [31:0] OFS_DATA   = 32'h0;
  localparam logic [31:0] OFS_STATUS = 32'h4;
  localparam logic [31:0] OFS_CTRL   = 32'h8;

  localparam int ST_EMPTY_BIT = 8;
  localparam int ST_FULL_BIT  = 9;
  localparam int ST_OVF_BIT   = 10;
  localparam int ST_UNF_BIT   = 11;

  localparam int CTRL_FLUSH_BIT   = 0;
  localparam int CTRL_CLR_OVF_BIT = 1;
  localparam int CTRL_CLR_UNF_BIT = 2;

  typedef enum logic [1:0] {
    REG_DATA,
    REG_STATUS,
    REG_CTRL,
    REG_NONE
  } reg_sel_e;

  function automatic reg_sel_e decode_reg(input logic [31:0] addr, input logic [31:0] base);
    reg_sel_e sel;
    sel = REG_NONE;
    if (addr == base + OFS_DATA)   sel = REG_DATA;
    if (addr == base + OFS_STATUS) sel = REG_STATUS;
    if (addr == base + OFS_CTRL)   sel = REG_CTRL;
    return sel;
  endfunction

  function automatic logic [31:0] pack_status(input logic [7:0] count, input logic empty,
                                              input logic full, input logic ovf, input logic unf);
    logic [31:0] st;
    st               = 32'h0;
    st[7:0]          = count;
    st[ST_EMPTY_BIT] = empty;
    st[ST_FULL_BIT]  = full;
    st[ST_OVF_BIT]   = ovf;
    st[ST_UNF_BIT]   = unf;
    return st;
  endfunction

endpackage

// File: rtl/gonso_sync_fifo.sv
// rtl/gonso_sync_fifo.sv - synchronous FIFO with registered count/full/empty and a flush input
module gonso_sync_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_push,
  input  logic                       i_pop,
  input  logic                       i_flush,
  input  logic [WIDTH-1:0]           i_data,
  output logic [WIDTH-1:0]           o_data,
  output logic [$clog2(DEPTH):0]     o_count,
  output logic                       o_full,
  output logic                       o_empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             r_full;
  logic             r_empty;

  logic             w_pop_ok;
  logic             w_push_ok;
  logic [CNT_W-1:0] w_count_nxt;

  // A pop on a full FIFO frees the slot the simultaneous push needs.
  assign w_pop_ok  = i_pop && !r_empty && !i_flush;
  assign w_push_ok = i_push && !i_flush && (!r_full || w_pop_ok);

  always_comb begin
    w_count_nxt = r_count;
    if (i_flush) begin
      w_count_nxt = '0;
    end else begin
      w_count_nxt = r_count + CNT_W'(w_push_ok) - CNT_W'(w_pop_ok);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push_ok) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
    end else begin
      if (i_flush) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
      end else begin
        if (w_push_ok) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
        if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      r_count <= w_count_nxt;
      r_full  <= (w_count_nxt == CNT_W'(DEPTH));
      r_empty <= (w_count_nxt == '0);
    end
  end

  assign o_data  = r_mem[r_rd_ptr];
  assign o_count = r_count;
  assign o_full  = r_full;
  assign o_empty = r_empty;

endmodule

// File: rtl/gonso_color_fifo.sv
// rtl/gonso_color_fifo.sv - color capture FIFO drained over a Wishbone slave with sticky loss flags
module gonso_color_fifo
  import gonso_pkg::*;
#(
  parameter int          DEPTH     = 16,
  parameter int          WIDTH     = 8,
  parameter logic [31:0] BASE_ADDR = 32'h30030010
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             color_valid_i,
  input  logic [WIDTH-1:0] color_i,
  input  logic             wbs_cyc_i,
  input  logic             wbs_stb_i,
  input  logic [31:0]      wishbone_address,
  input  logic             wbs_we_i,
  input  logic [31:0]      wbs_dat_i,
  input  logic [3:0]       wbs_sel_i,
  output logic [31:0]      wbs_dat_o,
  output logic             wbs_ack_o
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic        r_ack;
  logic [31:0] r_dat;
  logic        r_ovf;
  logic        r_unf;

  reg_sel_e         w_sel;
  logic             w_accept;
  logic             w_rd_data;
  logic             w_ctrl_wr;
  logic             w_flush;
  logic             w_clr_ovf;
  logic             w_clr_unf;
  logic             w_pop;
  logic             w_ovf_set;
  logic             w_unf_set;
  logic [WIDTH-1:0] w_head;
  logic [CNT_W-1:0] w_count;
  logic             w_full;
  logic             w_empty;
  logic [31:0]      w_status;
  logic [31:0]      w_rd_mux;
  logic             w_unused;

  assign w_unused = ^{wbs_dat_i[31:3], wbs_sel_i[3:1]};

  assign w_accept  = wbs_cyc_i && wbs_stb_i && !r_ack;
  assign w_sel     = decode_reg(wishbone_address, BASE_ADDR);
  assign w_rd_data = w_accept && !wbs_we_i && (w_sel == REG_DATA);
  assign w_ctrl_wr = w_accept && wbs_we_i && wbs_sel_i[0] && (w_sel == REG_CTRL);
  assign w_flush   = w_ctrl_wr && wbs_dat_i[CTRL_FLUSH_BIT];
  assign w_clr_ovf = w_ctrl_wr && wbs_dat_i[CTRL_CLR_OVF_BIT];
  assign w_clr_unf = w_ctrl_wr && wbs_dat_i[CTRL_CLR_UNF_BIT];

  assign w_pop     = w_rd_data && !w_empty;
  assign w_unf_set = w_rd_data && w_empty;
  // A push dropped by flush is intentional, so it is not counted as overflow.
  assign w_ovf_set = color_valid_i && w_full && !w_pop && !w_flush;

  gonso_sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (WIDTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (color_valid_i),
    .i_pop   (w_pop),
    .i_flush (w_flush),
    .i_data  (color_i),
    .o_data  (w_head),
    .o_count (w_count),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign w_status = pack_status(8'(w_count), w_empty, w_full, r_ovf, r_unf);

  always_comb begin
    w_rd_mux = 32'h0;
    case (w_sel)
      REG_DATA:   if (!w_empty) w_rd_mux = 32'(w_head);
      REG_STATUS: w_rd_mux = w_status;
      default:    w_rd_mux = 32'h0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ack <= 1'b0;
      r_dat <= 32'h0;
      r_ovf <= 1'b0;
      r_unf <= 1'b0;
    end else begin
      r_ack <= w_accept;
      if (w_accept && !wbs_we_i) begin
        r_dat <= w_rd_mux;
      end
      r_ovf <= w_ovf_set || (r_ovf && !w_clr_ovf);
      r_unf <= w_unf_set || (r_unf && !w_clr_unf);
    end
  end

  assign wbs_ack_o = r_ack;
  assign wbs_dat_o = r_dat;

endmodule
